onehot_seq_decoder: RTL and testbench
=====================================

// Module: onehot_seq_decoder
// PURPOSE
//   Parametrised, registered SEL_W-to-2**SEL_W one-hot decoder with active-low enable.
//   Adds sequencing modes: direct decode, auto-scan up/down with wrap, and strobe-pulse.
//   Drives row/strobe selects for peripheral and display-scan blocks in the lab datapath.
// PARAMETERS
//   SEL_W  3  select width; output width OUT_W = 2**SEL_W (localparam)
//   DIV    1  scan prescale: the scan index advances once every DIV enabled cycles (DIV>=1)
// PORTS
//   clk    in   1       single clock, all state on posedge
//   rst_   in   1       synchronous, active-low reset
//   enb_   in   1       active-low enable
//   mode   in   2       00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 PULSE
//   sel    in   SEL_W   decode index / scan load value
//   load   in   1       SCAN modes: idx <= sel on this edge
//   stb    in   1       PULSE mode strobe, edge-detected
//   o      out  OUT_W   one-hot output, registered
//   idx    out  SEL_W   index currently driven on o
//   wrap   out  1       1-cycle pulse on scan wrap
//   valid  out  1       1 when o holds a live one-hot value
// BEHAVIOUR
//   - Reset: rst_==0 at posedge -> o=0, idx=0, wrap=0, valid=0, prescaler=0, stb_q=0.
//     Reset overrides everything, including reset asserted mid-scan.
//   - All outputs are registered; inputs sampled at edge N appear on outputs after edge N.
//   - enb_==1: o<=0, valid<=0, wrap<=0; idx and prescaler hold; stb_q still tracks stb.
//   - enb_==0, per mode:
//     DECODE: idx<=sel, o<=1<<sel, valid<=1, wrap<=0. Prescaler cleared.
//     SCAN_UP: if load, then idx<=sel, prescaler<=0, no wrap.
//       Else on a tick (prescaler==DIV-1): idx<=idx+1 modulo 2**SEL_W.
//       wrap<=1 exactly when idx goes from 2**SEL_W-1 to 0.
//       Non-tick cycles: prescaler++ and idx holds.
//       o<=1<<next idx, valid<=1.
//     SCAN_DOWN: same as SCAN_UP with idx-1.
//       wrap<=1 exactly when idx goes from 0 to 2**SEL_W-1.
//     PULSE: stb_q<=stb every cycle.
//       On a rising edge (stb & ~stb_q): idx<=sel, o<=1<<sel, valid<=1 for exactly one cycle.
//       Otherwise o<=0, valid<=0, idx holds.
//       A held-high stb gives a single pulse.
//   - DIV==1: the scan advances every enabled cycle.
//   - Mode change: takes effect on the next edge with no flush cycle.
//     Scan continues from the current idx. The prescaler clears on any mode change.
//   - load is ignored outside the SCAN modes; stb is ignored outside PULSE.
//   - Invariant: o is either all-zero or exactly one-hot, and o==(valid ? 1<<idx : 0).
// STRUCTURE
//   - Shared header decoder_defs.vh holds the mode codes:
//     `MODE_DECODE, `MODE_SCAN_UP, `MODE_SCAN_DN, `MODE_PULSE.
//   - Sub-module scan_tick_gen (parameter DIV) provides the prescaler counter.
//     Ports: clk, rst_, run, clr, tick.
//   - Top level holds the idx register, the stb edge detector, wrap/valid logic and the one-hot encoder.
// TESTING (SEL_W=3 unless noted)
//   1. Reset and disable.
//      Stimulus: rst_=0 for 2 cycles, then enb_=1 with mode=DECODE, sel=5.
//      Required: o=8'h00, valid=0.
//   2. DECODE sweep.
//      Stimulus: enb_=0, sel=0..7, one per cycle.
//      Required: o=01,02,04..80, each one cycle after its sel.
//   3. SCAN_UP with DIV=1.
//      Stimulus: load with sel=6, then 3 cycles.
//      Required: idx=6,7,0,1; wrap=1 only on the 7->0 edge.
//   4. SCAN_DOWN with DIV=3.
//      Stimulus: load with sel=1.
//      Required: idx=1 for 3 cycles, 0 for 3 cycles, then 7 with wrap=1.
//   5. PULSE.
//      Stimulus: sel=4, stb held high for 5 cycles.
//      Required: o=8'h10 for exactly one cycle, then 0.
//   6. Reset mid-scan.
//      Stimulus: SCAN_UP at idx=5, rst_=0 for 1 cycle.
//      Required: o=0, idx=0; after release the scan restarts 0,1,...
//   - Every case asserts the one-hot/valid invariant on every cycle.

Source files
------------

// File: rtl/onehot_seq_decoder_pkg.sv
// Mode codes and shared types for the one-hot sequencing decoder.
// The macros keep the raw codes available to files that only use the preprocessor.
`ifndef ONEHOT_SEQ_DECODER_DEFS
`define ONEHOT_SEQ_DECODER_DEFS
`define MODE_DECODE  2'b00
`define MODE_SCAN_UP 2'b01
`define MODE_SCAN_DN 2'b10
`define MODE_PULSE   2'b11
`endif

package onehot_seq_decoder_pkg;
    typedef enum logic [1:0] {
        MODE_DECODE  = `MODE_DECODE,
        MODE_SCAN_UP = `MODE_SCAN_UP,
        MODE_SCAN_DN = `MODE_SCAN_DN,
        MODE_PULSE   = `MODE_PULSE
    } mode_e;
endpackage

// File: rtl/onehot_seq_decoder_scan_tick_gen.sv
// Scan prescaler: tick fires once every DIV running cycles.
// clr restarts the count; when run is also high the count restarts from zero on this very cycle.
module scan_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eff;

    always_comb begin
        cnt_eff = clr ? '0 : cnt;
        tick    = run && (cnt_eff == CNT_W'(DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt_eff + 1'b1;
        end else if (clr) begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/onehot_seq_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with active-low enable and
// direct-decode, scan-up/down (prescaled, wrapping) and strobe-pulse modes.
module onehot_seq_decoder
    import onehot_seq_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  enb_,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  load,
    input  logic                  stb,
    output logic [(1<<SEL_W)-1:0] o,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output logic                  valid
);
    localparam int OUT_W = 1 << SEL_W;

    mode_e            mode_c;
    mode_e            mode_q;
    logic             stb_q;
    logic             is_scan;
    logic             run;
    logic             clr;
    logic             tick;
    logic [SEL_W-1:0] idx_n;
    logic             valid_n;
    logic             wrap_n;

    // Prescaler restarts on DECODE/PULSE, on a load, and on any enabled mode change.
    always_comb begin
        mode_c  = mode_e'(mode);
        is_scan = (mode_c == MODE_SCAN_UP) || (mode_c == MODE_SCAN_DN);
        run     = !enb_ && is_scan && !load;
        clr     = !enb_ && ((mode_c != mode_q) || !is_scan || load);
    end

    scan_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_ (rst_),
        .run  (run),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        idx_n   = idx;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        if (!enb_) begin
            case (mode_c)
                MODE_DECODE: begin
                    idx_n   = sel;
                    valid_n = 1'b1;
                end
                MODE_SCAN_UP: begin
                    valid_n = 1'b1;
                    if (load) begin
                        idx_n = sel;
                    end else if (tick) begin
                        idx_n  = idx + 1'b1;
                        wrap_n = (idx == '1);
                    end
                end
                MODE_SCAN_DN: begin
                    valid_n = 1'b1;
                    if (load) begin
                        idx_n = sel;
                    end else if (tick) begin
                        idx_n  = idx - 1'b1;
                        wrap_n = (idx == '0);
                    end
                end
                MODE_PULSE: begin
                    if (stb && !stb_q) begin
                        idx_n   = sel;
                        valid_n = 1'b1;
                    end
                end
                default: begin
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            o      <= '0;
            idx    <= '0;
            wrap   <= 1'b0;
            valid  <= 1'b0;
            stb_q  <= 1'b0;
            mode_q <= MODE_DECODE;
        end else begin
            o      <= valid_n ? (OUT_W'(1) << idx_n) : '0;
            idx    <= idx_n;
            wrap   <= wrap_n;
            valid  <= valid_n;
            stb_q  <= stb;
            if (!enb_) begin
                mode_q <= mode_c;
            end
        end
    end
endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Bench for onehot_seq_decoder: DIV=1 and DIV=3 instances share stimulus and are
// compared every cycle against an integer-level reference model, plus directed cases.
module tb_onehot_seq_decoder;
    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       enb_ = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [2:0] sel = 3'd0;
    logic       load = 1'b0;
    logic       stb = 1'b0;

    logic [7:0] o_a [2];
    logic [2:0] idx_a [2];
    logic       wrap_a [2];
    logic       valid_a [2];

    int total = 0;
    int bad = 0;

    int m_idx [2];
    int m_cnt [2];
    int m_last [2];
    bit m_stbq [2];
    bit m_wrap [2];
    bit m_valid [2];
    int divs [2] = '{1, 3};

    always #5 clk = ~clk;

    onehot_seq_decoder #(.SEL_W(3), .DIV(1)) dut1 (
        .clk(clk), .rst_(rst_), .enb_(enb_), .mode(mode), .sel(sel), .load(load), .stb(stb),
        .o(o_a[0]), .idx(idx_a[0]), .wrap(wrap_a[0]), .valid(valid_a[0])
    );

    onehot_seq_decoder #(.SEL_W(3), .DIV(3)) dut3 (
        .clk(clk), .rst_(rst_), .enb_(enb_), .mode(mode), .sel(sel), .load(load), .stb(stb),
        .o(o_a[1]), .idx(idx_a[1]), .wrap(wrap_a[1]), .valid(valid_a[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: index as an integer mod 8, prescaler as a plain cycle count.
    task automatic model_update(input int k);
        bit rise;
        int c;
        if (!rst_) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_last[k] = 0;
            m_stbq[k] = 0; m_wrap[k] = 0; m_valid[k] = 0;
        end else begin
            rise = stb && !m_stbq[k];
            m_stbq[k] = stb;
            m_wrap[k] = 0;
            if (enb_) begin
                m_valid[k] = 0;
            end else begin
                c = (int'(mode) != m_last[k]) ? 0 : m_cnt[k];
                m_last[k] = int'(mode);
                m_valid[k] = 1;
                case (int'(mode))
                    0: begin m_idx[k] = int'(sel); m_cnt[k] = 0; end
                    1, 2: begin
                        if (load) begin
                            m_idx[k] = int'(sel); m_cnt[k] = 0;
                        end else if (c == divs[k] - 1) begin
                            m_cnt[k] = 0;
                            if (mode == 2'd1) begin
                                m_wrap[k] = (m_idx[k] == 7);
                                m_idx[k] = (m_idx[k] + 1) % 8;
                            end else begin
                                m_wrap[k] = (m_idx[k] == 0);
                                m_idx[k] = (m_idx[k] + 7) % 8;
                            end
                        end else begin
                            m_cnt[k] = c + 1;
                        end
                    end
                    default: begin
                        m_cnt[k] = 0;
                        if (rise) m_idx[k] = int'(sel);
                        else m_valid[k] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        logic [7:0] exp_o;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_o = m_valid[k] ? (8'd1 << m_idx[k]) : 8'd0;
            check($sformatf("o_div%0d", divs[k]), 32'(o_a[k]), 32'(exp_o));
            check($sformatf("idx_div%0d", divs[k]), 32'(idx_a[k]), 32'(m_idx[k]));
            check($sformatf("wrap_div%0d", divs[k]), 32'(wrap_a[k]), 32'(m_wrap[k]));
            check($sformatf("valid_div%0d", divs[k]), 32'(valid_a[k]), 32'(m_valid[k]));
            check($sformatf("invariant_div%0d", divs[k]), 32'(o_a[k]),
                  32'(valid_a[k] ? (8'd1 << idx_a[k]) : 8'd0));
        end
    endtask

    int exp_idx3 [3] = '{7, 0, 1};
    int exp_wrp3 [3] = '{0, 1, 0};
    int exp_idx4 [6] = '{1, 1, 0, 0, 0, 7};
    int exp_wrp4 [6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        // 1. reset and disable
        rst_ = 0; step(); step();
        check("rst_o", 32'(o_a[0]), 32'h00);
        check("rst_idx", 32'(idx_a[0]), 32'h0);
        check("rst_valid", 32'(valid_a[0]), 32'h0);
        rst_ = 1; enb_ = 1; mode = 2'b00; sel = 3'd5; step();
        check("dis_o", 32'(o_a[0]), 32'h00);
        check("dis_valid", 32'(valid_a[0]), 32'h0);

        // 2. decode sweep
        enb_ = 0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s); step();
            check($sformatf("decode_o%0d", s), 32'(o_a[0]), 32'(8'd1 << s));
        end

        // 3. scan up, DIV=1
        mode = 2'b01; load = 1; sel = 3'd6; step();
        check("up_load_idx", 32'(idx_a[0]), 32'd6);
        load = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("up_idx%0d", i), 32'(idx_a[0]), 32'(exp_idx3[i]));
            check($sformatf("up_wrap%0d", i), 32'(wrap_a[0]), 32'(exp_wrp3[i]));
        end

        // 4. scan down, DIV=3
        mode = 2'b10; load = 1; sel = 3'd1; step();
        check("dn_load_idx", 32'(idx_a[1]), 32'd1);
        load = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("dn_idx%0d", i), 32'(idx_a[1]), 32'(exp_idx4[i]));
            check($sformatf("dn_wrap%0d", i), 32'(wrap_a[1]), 32'(exp_wrp4[i]));
        end

        // 5. pulse with held strobe
        mode = 2'b11; sel = 3'd4; stb = 0; step();
        stb = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("pulse_o%0d", i), 32'(o_a[0]), (i == 0) ? 32'h10 : 32'h00);
        end
        stb = 0; step();

        // 6. reset mid-scan
        mode = 2'b01; load = 1; sel = 3'd5; step();
        check("mid_idx", 32'(idx_a[0]), 32'd5);
        load = 0; rst_ = 0; step();
        check("mid_rst_o", 32'(o_a[0]), 32'h00);
        check("mid_rst_idx", 32'(idx_a[0]), 32'd0);
        rst_ = 1; step();
        check("restart_idx1", 32'(idx_a[0]), 32'd1);
        step();
        check("restart_idx2", 32'(idx_a[0]), 32'd2);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_ = ($urandom_range(0, 49) != 0);
            enb_ = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            sel  = 3'($urandom_range(0, 7));
            load = ($urandom_range(0, 7) == 0);
            stb  = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
